// File: rtl/uart_cmd_frame_rx.sv
// uart_cmd_frame_rx
//   UART command-frame receiver for the motor controller register interface.
//   Frame on the line: start | RW | ADDR | DATA | [parity] | stop.
//   Fields are sent LSB first. Each bit is 3-sample majority voted around mid-bit.
//   A good frame produces a one-cycle cmd_valid strobe. A parity or framing
//   failure produces a one-cycle err_valid strobe instead.
// Ports
//   clk_in     system clock
//   rst        synchronous, active-low reset
//   rx_in      asynchronous serial line, idle high
//   cmd_valid  strobe: error-free frame received
//   cmd_rw     1 = read, 0 = write (held until next cmd_valid)
//   cmd_addr   address field (held until next cmd_valid)
//   cmd_data   data field (held until next cmd_valid)
//   err_valid  strobe: frame rejected
//   err_parity qualifies err_valid: parity mismatch
//   err_frame  qualifies err_valid: stop bit sampled low
//   busy       high from start-edge detection until return to IDLE
module uart_cmd_frame_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 4,
  parameter int PARITY_MODE  = 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              rx_in,
  output logic              cmd_valid,
  output logic              cmd_rw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic              err_valid,
  output logic              err_parity,
  output logic              err_frame,
  output logic              busy
);
  localparam int NB = 1 + ADDR_W + DATA_W;
  localparam int BW = $clog2(NB + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {IDLE, START, SHIFT, PARITY, STOP, BREAK} state_t;
  state_t state, state_nxt;

  logic          rx_m, rx_s;
  logic [CW-1:0] c;
  logic [BW-1:0] bcnt;
  logic          s0, s1;
  logic [NB-1:0] sr;
  logic          par_bit;
  logic          mid, bit_v, par_ok;

  // Decision point: third vote is the live synchronised sample.
  assign mid   = (c == CW'(H + 1));
  assign bit_v = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign busy  = (state != IDLE);

  always_comb begin
    par_ok = 1'b1;
    if (PARITY_MODE == 1)      par_ok = ((^sr) == par_bit);
    else if (PARITY_MODE == 2) par_ok = ((^sr) != par_bit);
  end

  always_ff @(posedge clk_in) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // State changes happen at the mid-bit decision; the bit counter keeps
  // running so the next decision lands mid-way through the following bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START:  if (mid) state_nxt = bit_v ? IDLE : SHIFT;
      SHIFT:  if (mid && bcnt == BW'(NB - 1))
                state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY: if (mid) state_nxt = STOP;
      // Leaving at mid-stop lets a start bit right after the stop bit be seen.
      STOP:   if (mid) state_nxt = bit_v ? IDLE : BREAK;
      BREAK:  if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      c          <= '0;
      bcnt       <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      sr         <= '0;
      par_bit    <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_rw     <= 1'b0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      err_valid  <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      rx_m       <= rx_in;
      rx_s       <= rx_m;
      cmd_valid  <= 1'b0;
      err_valid  <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;

      if (state == IDLE || state == BREAK) c <= '0;
      else if (c == CW'(CLKS_PER_BIT - 1)) c <= '0;
      else c <= c + CW'(1);

      if (c == CW'(H - 1)) s0 <= rx_s;
      if (c == CW'(H))     s1 <= rx_s;

      case (state)
        START:  bcnt <= '0;
        SHIFT:  if (mid) begin
                  sr   <= {bit_v, sr[NB-1:1]};
                  bcnt <= bcnt + BW'(1);
                end
        PARITY: if (mid) par_bit <= bit_v;
        STOP:   if (mid) begin
                  if (bit_v && par_ok) begin
                    cmd_valid <= 1'b1;
                    cmd_rw    <= sr[0];
                    cmd_addr  <= sr[ADDR_W:1];
                    cmd_data  <= sr[NB-1:ADDR_W+1];
                  end else if (bit_v) begin
                    err_valid  <= 1'b1;
                    err_parity <= 1'b1;
                  end else begin
                    err_valid  <= 1'b1;
                    err_frame  <= 1'b1;
                    err_parity <= !par_ok;
                  end
                end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_frame_rx.sv
// Directed bench for uart_cmd_frame_rx: default widths / even parity on dut1,
// 4-bit address / 8-bit data / odd parity on dut2. CLKS_PER_BIT = 16.
module tb_uart_cmd_frame_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx1, rx2;

  logic       cmd_valid, cmd_rw, err_valid, err_parity, err_frame, busy;
  logic [2:0] cmd_addr;
  logic [3:0] cmd_data;

  logic       cmd_valid2, cmd_rw2, err_valid2, err_parity2, err_frame2, busy2;
  logic [3:0] cmd_addr2;
  logic [7:0] cmd_data2;

  int checks = 0, errors = 0;
  int cmd_cnt = 0, err_cnt = 0, bad_cnt = 0;
  int cmd2_cnt = 0, err2_cnt = 0, bad2_cnt = 0;
  logic [7:0]  cmd_log [16];
  logic [1:0]  last_err = '0;
  logic [12:0] last2 = '0;

  always #5 clk = ~clk;

  uart_cmd_frame_rx #(.CLKS_PER_BIT(CPB), .ADDR_W(3), .DATA_W(4), .PARITY_MODE(1)) dut1 (
    .clk_in(clk), .rst(rst), .rx_in(rx1),
    .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .err_valid(err_valid), .err_parity(err_parity), .err_frame(err_frame), .busy(busy));

  uart_cmd_frame_rx #(.CLKS_PER_BIT(CPB), .ADDR_W(4), .DATA_W(8), .PARITY_MODE(2)) dut2 (
    .clk_in(clk), .rst(rst), .rx_in(rx2),
    .cmd_valid(cmd_valid2), .cmd_rw(cmd_rw2), .cmd_addr(cmd_addr2), .cmd_data(cmd_data2),
    .err_valid(err_valid2), .err_parity(err_parity2), .err_frame(err_frame2), .busy(busy2));

  // Strobe monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmd_valid) begin
      if (cmd_cnt < 16) cmd_log[cmd_cnt] <= {cmd_rw, cmd_addr, cmd_data};
      cmd_cnt <= cmd_cnt + 1;
    end
    if (err_valid) begin
      last_err <= {err_parity, err_frame};
      err_cnt  <= err_cnt + 1;
    end
    if ((cmd_valid && err_valid) || (!err_valid && (err_parity || err_frame)))
      bad_cnt <= bad_cnt + 1;
    if (cmd_valid2) begin
      last2    <= {cmd_rw2, cmd_addr2, cmd_data2};
      cmd2_cnt <= cmd2_cnt + 1;
    end
    if (err_valid2) err2_cnt <= err2_cnt + 1;
    if ((cmd_valid2 && err_valid2) || (!err_valid2 && (err_parity2 || err_frame2)))
      bad2_cnt <= bad2_cnt + 1;
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL timeout: bench did not finish within 30000 cycles");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hold(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives n bits LSB first; optional one-clock inversion at offset 9 of bit spike_bit.
  task automatic send_bits(input logic [15:0] bits, input int n, input int sel, input int spike_bit);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < CPB; k++) begin
        logic b;
        b = bits[i] ^ ((i == spike_bit) && (k == 9));
        if (sel == 0) rx1 = b;
        else          rx2 = b;
        @(posedge clk); #1;
      end
    end
  endtask

  function automatic logic [15:0] fr(input logic rw, input logic [2:0] a, input logic [3:0] d,
                                     input logic p, input logic s);
    return {5'b0, s, p, d, a, rw, 1'b0};
  endfunction

  function automatic logic [15:0] fr2(input logic rw, input logic [3:0] a, input logic [7:0] d,
                                      input logic p, input logic s);
    return {s, p, d, a, rw, 1'b0};
  endfunction

  initial begin
    rst = 1'b0;
    rx1 = 1'b1;
    rx2 = 1'b1;
    hold(4);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_rw", cmd_rw, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_parity", err_parity, 0);
    chk("rst_err_frame", err_frame, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_cmd_data2", cmd_data2, 0);
    rst = 1'b1;
    idle(32);
    chk("idle_busy", busy, 0);

    // 1: write, addr 3, data A, even parity 0
    send_bits(fr(1'b0, 3'd3, 4'hA, 1'b0, 1'b1), 11, 0, -1);
    idle(32);
    chk("s1_cmd_cnt", cmd_cnt, 1);
    chk("s1_fields", cmd_log[0], 8'h3A);
    chk("s1_err_cnt", err_cnt, 0);

    // 2: read, addr 0, data 8, parity 0; then same frame with bad parity
    send_bits(fr(1'b1, 3'd0, 4'h8, 1'b0, 1'b1), 11, 0, -1);
    idle(32);
    chk("s2_cmd_cnt", cmd_cnt, 2);
    chk("s2_fields", cmd_log[1], 8'h88);
    send_bits(fr(1'b1, 3'd0, 4'h8, 1'b1, 1'b1), 11, 0, -1);
    idle(32);
    chk("s2p_err_cnt", err_cnt, 1);
    chk("s2p_err_bits", last_err, 2'b10);
    chk("s2p_cmd_cnt", cmd_cnt, 2);
    chk("s2p_hold_rw", cmd_rw, 1);
    chk("s2p_hold_addr", cmd_addr, 0);
    chk("s2p_hold_data", cmd_data, 4'h8);

    // 3: stop bit low, then line stuck low for 40 bit-times
    send_bits(fr(1'b0, 3'd3, 4'hA, 1'b0, 1'b0), 11, 0, -1);
    hold(20 * CPB);
    chk("s3_busy_a", busy, 1);
    chk("s3_err_cnt", err_cnt, 2);
    chk("s3_err_bits", last_err, 2'b01);
    hold(20 * CPB);
    chk("s3_busy_b", busy, 1);
    chk("s3_err_cnt_b", err_cnt, 2);
    chk("s3_cmd_cnt", cmd_cnt, 2);
    idle(8);
    chk("s3_release_busy", busy, 0);

    // 4a: 3-clock low glitch is taken as a start edge, then rejected
    rx1 = 1'b0;
    hold(3);
    rx1 = 1'b1;
    hold(2);
    chk("s4_glitch_busy", busy, 1);
    idle(48);
    chk("s4_glitch_busy_end", busy, 0);
    chk("s4_glitch_cmd_cnt", cmd_cnt, 2);
    chk("s4_glitch_err_cnt", err_cnt, 2);

    // 4b: one-clock spike inside data[1] is out-voted
    send_bits(fr(1'b0, 3'd3, 4'hA, 1'b0, 1'b1), 11, 0, 6);
    idle(32);
    chk("s4_spike_cmd_cnt", cmd_cnt, 3);
    chk("s4_spike_fields", cmd_log[2], 8'h3A);
    chk("s4_spike_err_cnt", err_cnt, 2);

    // 5: back-to-back frames, zero idle between them
    send_bits(fr(1'b0, 3'd1, 4'h5, 1'b1, 1'b1), 11, 0, -1);
    send_bits(fr(1'b0, 3'd6, 4'hC, 1'b0, 1'b1), 11, 0, -1);
    idle(32);
    chk("s5_cmd_cnt", cmd_cnt, 5);
    chk("s5_fields_a", cmd_log[3], 8'h15);
    chk("s5_fields_b", cmd_log[4], 8'h6C);
    chk("s5_err_cnt", err_cnt, 2);

    // 5r: reset in the middle of a frame
    send_bits(fr(1'b0, 3'd6, 4'hC, 1'b0, 1'b1), 5, 0, -1);
    chk("s5r_busy_pre", busy, 1);
    rst = 1'b0;
    hold(2);
    chk("s5r_addr", cmd_addr, 0);
    chk("s5r_data", cmd_data, 0);
    chk("s5r_busy", busy, 0);
    chk("s5r_valid", cmd_valid, 0);
    rx1 = 1'b1;
    rst = 1'b1;
    idle(12 * CPB);
    chk("s5r_cmd_cnt", cmd_cnt, 5);
    chk("s5r_err_cnt", err_cnt, 2);
    chk("s5r_busy_after", busy, 0);

    // 6: odd parity, 4-bit address, 8-bit data
    send_bits(fr2(1'b0, 4'h9, 8'hA5, 1'b1, 1'b1), 16, 1, -1);
    idle(32);
    chk("s6_cmd_cnt", cmd2_cnt, 1);
    chk("s6_fields", last2, {1'b0, 4'h9, 8'hA5});
    chk("s6_err_cnt", err2_cnt, 0);
    chk("s6_dut1_quiet", cmd_cnt, 5);

    chk("strobe_rules_dut1", bad_cnt, 0);
    chk("strobe_rules_dut2", bad2_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
